// File: rtl/tt_extractor_pkg.sv
// tt_extractor_pkg
//   Shared definitions for the truth-table extractor:
//   - state_t   : sweep FSM states
//   - N_IN_MAX  : largest supported gate input count
//   - TT_W_MAX  : truth-table width at N_IN_MAX
//   - popcount  : number of set bits in a (zero-extended) table word
package tt_extractor_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      COMPARE,
      DONE
   } state_t;

   localparam int N_IN_MAX = 6;
   localparam int TT_W_MAX = 1 << N_IN_MAX;

   function automatic int popcount(input logic [TT_W_MAX-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < TT_W_MAX; i++) begin
         c = c + int'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/tt_extractor_if.sv
// tt_extractor_if
//   Bundles the sweep control, gate probe and result signals.
//   master : bench / characterization controller side (drives start,
//            expected_tt and returns the gate output on probe_in)
//   slave  : the extractor itself
//   Signals:
//     start        - begin a sweep
//     expected_tt  - reference table, captured on an accepted start
//     probe_out    - input vector driven into the gate under test
//     probe_in     - gate output
//     busy, done   - sweep in progress / one-cycle completion pulse
//     tt           - extracted truth table
//     mismatch_cnt - popcount(tt ^ captured expected table)
//     match, valid - result agrees with reference / result is complete
interface tt_extractor_if #(
   parameter int N_IN = 4
);
   localparam int TT_W = 1 << N_IN;

   logic              start;
   logic [TT_W-1:0]   expected_tt;
   logic [N_IN-1:0]   probe_out;
   logic              probe_in;
   logic              busy;
   logic              done;
   logic [TT_W-1:0]   tt;
   logic [N_IN:0]     mismatch_cnt;
   logic              match;
   logic              valid;

   modport master (
      output start, expected_tt, probe_in,
      input  probe_out, busy, done, tt, mismatch_cnt, match, valid
   );

   modport slave (
      input  start, expected_tt, probe_in,
      output probe_out, busy, done, tt, mismatch_cnt, match, valid
   );

endinterface

// File: rtl/tt_extractor_popcount.sv
// tt_popcount
//   Purely combinational population count of a 2^N_IN-bit word.
//   Ports:
//     bits  - input word (2^N_IN bits)
//     count - number of ones (N_IN+1 bits, wide enough for all-ones)
module tt_popcount
   import tt_extractor_pkg::*;
#(
   parameter int N_IN = 4
) (
   input  logic [(1 << N_IN)-1:0] bits,
   output logic [N_IN:0]          count
);

   localparam int CW = N_IN + 1;

   logic [TT_W_MAX-1:0] ext;

   always_comb begin
      ext   = TT_W_MAX'(bits);
      count = CW'(popcount(ext));
   end

endmodule

// File: rtl/tt_extractor.sv
// tt_extractor
//   Sweeps every input combination of a combinational gate under test,
//   holds each vector SETTLE cycles, samples the gate output, builds the
//   2^N_IN-bit truth table and counts mismatches against a reference.
//   Parameters:
//     N_IN   - gate input count (1..6)
//     SETTLE - DRIVE cycles per vector before the sample cycle (>= 1)
//   Ports:
//     clk - clock, rising edge
//     rst - asynchronous active-high reset
//     bus - tt_extractor_if slave modport (control, probes, results)
module tt_extractor
   import tt_extractor_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int SETTLE = 2
) (
   input logic          clk,
   input logic          rst,
   tt_extractor_if.slave bus
);

   localparam int TT_W  = 1 << N_IN;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

   state_t            state;
   logic [N_IN-1:0]   idx;
   logic [CNT_W-1:0]  cnt;
   logic [TT_W-1:0]   exp_q;
   logic [TT_W-1:0]   tt_q;
   logic [N_IN-1:0]   probe_q;
   logic              busy_q;
   logic              done_q;
   logic [N_IN:0]     mism_q;
   logic              match_q;
   logic              valid_q;
   logic [N_IN:0]     pc;

   tt_popcount #(.N_IN(N_IN)) u_popcount (
      .bits  (tt_q ^ exp_q),
      .count (pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         cnt     <= '0;
         exp_q   <= '0;
         tt_q    <= '0;
         probe_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mism_q  <= '0;
         match_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  exp_q   <= bus.expected_tt;
                  tt_q    <= '0;
                  valid_q <= 1'b0;
                  match_q <= 1'b0;
                  mism_q  <= '0;
                  idx     <= '0;
                  cnt     <= CNT_LOAD;
                  probe_q <= '0;
                  busy_q  <= 1'b1;
                  state   <= DRIVE;
               end
            end
            DRIVE: begin
               if (cnt == '0) begin
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SAMPLE: begin
               tt_q[idx] <= bus.probe_in;
               // Terminal test on all-ones so idx never wraps mid-sweep.
               if (idx == '1) begin
                  probe_q <= '0;
                  busy_q  <= 1'b0;
                  state   <= COMPARE;
               end else begin
                  idx     <= idx + 1'b1;
                  probe_q <= idx + 1'b1;
                  cnt     <= CNT_LOAD;
                  state   <= DRIVE;
               end
            end
            COMPARE: begin
               mism_q <= pc;
               state  <= DONE;
            end
            DONE: begin
               // Registered, so done/valid/match appear as the FSM is back
               // in IDLE; a start seen on this edge is not accepted.
               done_q  <= 1'b1;
               valid_q <= 1'b1;
               match_q <= (mism_q == '0);
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.probe_out    = probe_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.tt           = tt_q;
   assign bus.mismatch_cnt = mism_q;
   assign bus.match        = match_q;
   assign bus.valid        = valid_q;

endmodule

// File: tb/tb_tt_extractor.sv
// tb_tt_extractor
//   Three extractor instances: (N_IN=4,SETTLE=2), (N_IN=4,SETTLE=1) and
//   (N_IN=2,SETTLE=3). Each gate under test is a lookup into a bench-held
//   truth table. A cycle-count model of the main instance is compared on
//   every falling edge; directed sweeps pin literal results and latencies.
module tb_tt_extractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   tt_extractor_if #(.N_IN(4)) bus0 ();
   tt_extractor_if #(.N_IN(4)) bus1 ();
   tt_extractor_if #(.N_IN(2)) bus2 ();

   logic [15:0] gate0, gate1;
   logic [3:0]  gate2;

   assign bus0.probe_in = gate0[bus0.probe_out];
   assign bus1.probe_in = gate1[bus1.probe_out];
   assign bus2.probe_in = gate2[bus2.probe_out];

   tt_extractor #(.N_IN(4), .SETTLE(2)) u0 (.clk(clk), .rst(rst), .bus(bus0));
   tt_extractor #(.N_IN(4), .SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
   tt_extractor #(.N_IN(2), .SETTLE(3)) u2 (.clk(clk), .rst(rst), .bus(bus2));

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pop16(input logic [15:0] v);
      int c = 0;
      for (int i = 0; i < 16; i++) if (v[i]) c++;
      return c;
   endfunction

   // ---------------- behavioural model of u0 ----------------
   // k counts cycles since the accepted start edge (k=1 is the first cycle
   // after it); 0 means idle. Each vector occupies S0+1 cycles, then one
   // compare cycle, one done-state cycle, and the done pulse is seen as the
   // extractor is back in idle (k = L0+3), where a new start is accepted.
   localparam int S0 = 2;
   localparam int V0 = 16;
   localparam int L0 = V0 * (S0 + 1);

   int          k;
   logic [15:0] gcap, ecap, tt_last;
   bit          vld_m;
   bit          run_cmp = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k = 0; gcap = '0; ecap = '0; tt_last = '0; vld_m = 1'b0;
      end else if ((k == 0 || k == L0 + 3) && bus0.start) begin
         k = 1; gcap = gate0; ecap = bus0.expected_tt; vld_m = 1'b0;
      end else if (k == L0 + 3) begin
         k = 0; tt_last = gcap;
      end else if (k != 0) begin
         k++;
         if (k == L0 + 3) vld_m = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         logic        busy_e;
         logic [3:0]  probe_e;
         logic [15:0] tt_e;
         busy_e  = (k >= 1 && k <= L0);
         probe_e = busy_e ? 4'((k - 1) / (S0 + 1)) : 4'd0;
         if (k == 0) tt_e = tt_last;
         else begin
            tt_e = '0;
            for (int i = 0; i < V0; i++) if ((i + 1) * (S0 + 1) < k) tt_e[i] = gcap[i];
         end
         check("busy",      64'(bus0.busy),      64'(busy_e));
         check("probe_out", 64'(bus0.probe_out), 64'(probe_e));
         check("done",      64'(bus0.done),      64'(k == L0 + 3));
         check("valid",     64'(bus0.valid),     64'(vld_m));
         check("tt",        64'(bus0.tt),        64'(tt_e));
         if (vld_m) begin
            check("mismatch_cnt", 64'(bus0.mismatch_cnt), 64'(pop16(gcap ^ ecap)));
            check("match",        64'(bus0.match),        64'(gcap == ecap));
         end
      end
   end

   // ---------------- stimulus helpers for u0 ----------------
   // Called at posedge+1; returns at posedge+2 after the hold.
   task automatic start0(input logic [15:0] g, input logic [15:0] e, input int hold);
      #1;
      gate0 = g;
      bus0.expected_tt = e;
      bus0.start = 1'b1;
      repeat (hold) @(posedge clk);
      #2 bus0.start = 1'b0;
   endtask

   // Counts rising edges until done is seen; returns at posedge+1.
   task automatic wait_done0(output int lat);
      bit found = 1'b0;
      lat = 0;
      for (int c = 0; c < 300 && !found; c++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus0.done) found = 1'b1;
      end
      if (!found) begin
         check("u0_done_timeout", 64'd0, 64'd1);
         lat = -1;
      end
   endtask

   initial begin
      int lat;
      int lat1;
      bit found;

      rst = 1'b1;
      bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
      bus0.expected_tt = '0; bus1.expected_tt = '0; bus2.expected_tt = '0;
      gate0 = '0; gate1 = '0; gate2 = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_probe_out", 64'(bus0.probe_out),    64'd0);
      check("rst_busy",      64'(bus0.busy),         64'd0);
      check("rst_done",      64'(bus0.done),         64'd0);
      check("rst_tt",        64'(bus0.tt),           64'd0);
      check("rst_mism",      64'(bus0.mismatch_cnt), 64'd0);
      check("rst_match",     64'(bus0.match),        64'd0);
      check("rst_valid",     64'(bus0.valid),        64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      run_cmp = 1'b1;

      // AND4
      start0(16'h8000, 16'h8000, 1);
      wait_done0(lat);
      check("and4_latency", 64'(lat),               64'd50);
      check("and4_tt",      64'(bus0.tt),           64'h8000);
      check("and4_mism",    64'(bus0.mismatch_cnt), 64'd0);
      check("and4_match",   64'(bus0.match),        64'd1);

      // XOR4 parity
      start0(16'h6996, 16'h6996, 1);
      wait_done0(lat);
      check("xor4_tt",    64'(bus0.tt),    64'h6996);
      check("xor4_match", 64'(bus0.match), 64'd1);

      // Constant 1 against an all-zero reference
      start0(16'hFFFF, 16'h0000, 1);
      wait_done0(lat);
      check("one_tt",    64'(bus0.tt),           64'hFFFF);
      check("one_mism",  64'(bus0.mismatch_cnt), 64'd16);
      check("one_match", 64'(bus0.match),        64'd0);
      check("one_valid", 64'(bus0.valid),        64'd1);

      // start while busy is ignored; start in the done cycle is accepted
      start0(16'h1234, 16'h1234, 1);
      repeat (10) @(posedge clk);
      #2 bus0.start = 1'b1;
      @(posedge clk);
      #2 bus0.start = 1'b0;
      wait_done0(lat);
      check("busy_pulse_latency", 64'(lat + 11), 64'd50);
      #1;
      gate0 = 16'hA5A5;
      bus0.expected_tt = 16'h0000;
      bus0.start = 1'b1;
      @(posedge clk);
      #1 check("restart_valid_low", 64'(bus0.valid), 64'd0);
      check("restart_busy",         64'(bus0.busy),  64'd1);
      #1 bus0.start = 1'b0;
      wait_done0(lat);
      check("restart_latency", 64'(lat),               64'd50);
      check("restart_tt",      64'(bus0.tt),           64'hA5A5);
      check("restart_mism",    64'(bus0.mismatch_cnt), 64'd8);
      check("restart_match",   64'(bus0.match),        64'd0);

      // randomized sweeps
      for (int it = 0; it < 24; it++) begin
         logic [15:0] g, e;
         int hold;
         g = 16'($urandom);
         case ($urandom_range(0, 2))
            0: e = g;
            1: e = g ^ (16'd1 << $urandom_range(0, 15));
            default: e = 16'($urandom);
         endcase
         hold = $urandom_range(1, 3);
         start0(g, e, hold);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(2, 30)) @(posedge clk);
            #2 bus0.start = 1'b1;
            @(posedge clk);
            #2 bus0.start = 1'b0;
         end
         wait_done0(lat);
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end

      // reset in the middle of a sweep at idx 7
      start0(16'hFFFF, 16'h0000, 1);
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(posedge clk);
         #1;
         if (bus0.probe_out == 4'd7) found = 1'b1;
      end
      check("reach_idx7", 64'(found), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_probe_out", 64'(bus0.probe_out),    64'd0);
      check("mid_rst_busy",      64'(bus0.busy),         64'd0);
      check("mid_rst_done",      64'(bus0.done),         64'd0);
      check("mid_rst_tt",        64'(bus0.tt),           64'd0);
      check("mid_rst_mism",      64'(bus0.mismatch_cnt), 64'd0);
      check("mid_rst_match",     64'(bus0.match),        64'd0);
      check("mid_rst_valid",     64'(bus0.valid),        64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // SETTLE=1 instance: 16*2+2 = 34 cycles
      #1;
      gate1 = 16'($urandom);
      bus1.expected_tt = gate1;
      bus1.start = 1'b1;
      @(posedge clk);
      #2 bus1.start = 1'b0;
      found = 1'b0; lat1 = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(posedge clk);
         #1;
         lat1++;
         if (bus1.done) found = 1'b1;
      end
      check("s1_done_seen", 64'(found),              64'd1);
      check("s1_latency",   64'(lat1),               64'd34);
      check("s1_tt",        64'(bus1.tt),            64'(gate1));
      check("s1_mism",      64'(bus1.mismatch_cnt),  64'd0);
      check("s1_match",     64'(bus1.match),         64'd1);

      // N_IN=2, SETTLE=3 OR gate: 4*4+2 = 18 cycles
      #1;
      gate2 = 4'hE;
      bus2.expected_tt = 4'hE;
      bus2.start = 1'b1;
      @(posedge clk);
      #2 bus2.start = 1'b0;
      found = 1'b0; lat1 = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(posedge clk);
         #1;
         lat1++;
         if (bus2.done) found = 1'b1;
      end
      check("or2_done_seen", 64'(found),             64'd1);
      check("or2_latency",   64'(lat1),              64'd18);
      check("or2_tt",        64'(bus2.tt),           64'hE);
      check("or2_mism",      64'(bus2.mismatch_cnt), 64'd0);
      check("or2_match",     64'(bus2.match),        64'd1);
      check("or2_valid",     64'(bus2.valid),        64'd1);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/tt_extractor.md
# tt_extractor

Sequential truth-table extractor, the measurement counterpart to our synthesized combinational gate netlists. It drives every input combination into a combinational gate under test, waits a programmable settle time, samples the gate output, and assembles the full 2^N_IN-bit truth-table word, e.g. 0x6996 for a 4-input parity gate. It also compares the word against an expected table and reports a mismatch count. It sits in the characterization bench around any generated `gate` netlist.

## Interface
Parameters:
- N_IN, default 4: number of gate-under-test inputs. Legal range 1..6.
- SETTLE, default 2: cycles each vector is held before sampling. Must be at least 1.

Ports:
- clk, in, 1: single clock. All state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: begin a sweep. Sampled only in IDLE.
- expected_tt, in, 2^N_IN: reference truth table. Captured on accepted start.
- probe_out, out, N_IN: vector driven to the gate. probe_out[k] drives gate input _k.
- probe_in, in, 1: gate output.
- busy, out, 1: high from the cycle after an accepted start through the last SAMPLE cycle.
- done, out, 1: one-cycle pulse when the sweep completes.
- tt, out, 2^N_IN: extracted table. tt[i] = f(probe_out == i).
- mismatch_cnt, out, N_IN+1: popcount of tt XOR captured expected_tt.
- match, out, 1: mismatch_cnt == 0. Meaningful only while valid is high.
- valid, out, 1: tt, mismatch_cnt and match hold a completed result.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, COMPARE, DONE.
- IDLE:
  - On start: capture expected_tt, clear tt, clear valid, set idx=0 and settle counter=SETTLE-1, then go to DRIVE.
- DRIVE:
  - probe_out = idx.
  - Counter decrements each cycle. When it reaches 0, go to SAMPLE.
- SAMPLE:
  - probe_out still = idx. Write tt[idx] <= probe_in.
  - If idx == 2^N_IN-1, go to COMPARE.
  - Otherwise idx++, reload the counter, and go to DRIVE.
- COMPARE:
  - One cycle. Compute mismatch_cnt = popcount(tt ^ exp_q), then go to DONE.
- DONE:
  - One cycle. done=1 and valid<=1, then go to IDLE.
- idx is N_IN bits wide and must not wrap mid-sweep; the terminal test is on the all-ones value.
- probe_out is 0 in IDLE, COMPARE and DONE.
- start outside IDLE is ignored. No queuing.
- start on the same edge that DONE returns to IDLE is not accepted; start is accepted only while already in IDLE.
- Results (tt, mismatch_cnt, match) hold until the next accepted start. valid drops on that start.
- Reset at any point: state=IDLE, all outputs 0 (probe_out, busy, done, tt, mismatch_cnt, match, valid). The captured expected table clears. Any sweep in progress is abandoned with no partial result flagged valid.

## Timing
- Per vector: SETTLE DRIVE cycles + 1 SAMPLE cycle.
- Latency from the start edge to the done pulse: 2^N_IN·(SETTLE+1) + 2 cycles. For the defaults, 16·3+2 = 50.
- busy asserts the cycle after start, covering DRIVE and SAMPLE. It is low in COMPARE, DONE and IDLE.
- probe_out changes only on the DRIVE entry edge. It is stable for SETTLE+1 cycles before and including the sample edge.
- probe_in is sampled on the rising edge that ends SAMPLE. The gate's combinational path must settle within SETTLE cycles.
- valid and match rise together with done and stay high.

## Structure
- Package tt_extractor_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, COMPARE, DONE);
  - the localparam TT_W = 1 << N_IN;
  - a popcount function.
- One sub-module, tt_popcount: purely combinational, TT_W in, N_IN+1 out. It is instantiated for mismatch_cnt and is separately testable.
- Top level: FSM, settle counter, idx counter, tt shift/index register, expected-table register.

## Test plan
- AND4 gate, defaults, expected_tt=0x8000 → tt=0x8000, mismatch_cnt=0, match=1, done exactly 50 cycles after start.
- XOR4 parity gate, expected_tt=0x6996 → tt=0x6996, match=1. Also check that probe_out steps 0..15, holding each value 3 cycles.
- Constant-1 gate, expected_tt=0x0000 → tt=0xFFFF, mismatch_cnt=16, match=0, valid=1.
- start pulsed while busy, then again one cycle after done → first extra pulse ignored; second starts a new sweep, with valid low until its done.
- rst asserted mid-sweep at idx=7 → all outputs 0 immediately, regardless of clock. A subsequent sweep with SETTLE=1 (N_IN=4) completes in 34 cycles with a correct table.
- N_IN=2, SETTLE=3, OR gate, expected_tt=0xE → tt=0xE, match=1, done after 18 cycles.
